mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/mem_ctrl_ram16x8.sv | 66 ++++++
 rtl/mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the memory controller:
//   - FSM state encoding (LOAD / START / RUN) as seen on the state port
//   - address/data widths of the 16x8 memory
//   - width and default limit of the loader wait (timeout) counter
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int ADDR_W          = 4;
    localparam int DATA_W          = 8;
    localparam int MEM_DEPTH       = 1 << ADDR_W;
    localparam int WAIT_W          = 4;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_START = 2'b01,
        ST_RUN   = 2'b10
    } state_e;

endpackage : mem_ctrl_pkg

// File: rtl/mem_ctrl_ram16x8.sv
// -----------------------------------------------------------------------------
// ram16x8
//   16 x 8 storage array with:
//   - port A: combinational read (zero latency)
//   - port B: synchronous read into a holding register, updated only when
//             re_b_i=1, so the last read value stays visible between reads
//   - one synchronous write port
//   - synchronous active-low clear of every byte and of the port-B register
//
// Ports
//   clk        in   clock
//   clr_n_i    in   synchronous clear, active-low
//   raddr_a_i  in   port A read address
//   rdata_a_o  out  port A read data (combinational)
//   re_b_i     in   port B read enable
//   raddr_b_i  in   port B read address
//   rdata_b_o  out  port B registered read data
//   we_i       in   write enable
//   waddr_i    in   write address
//   wdata_i    in   write data
// -----------------------------------------------------------------------------
module ram16x8
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic              re_b_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_b_q;

    // NOTE: clearing the array on reset turns it into flip-flops rather than
    // a RAM macro; that is intended here because the contents must read as
    // zero straight after clear.
    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Port B reads the pre-write contents; the controller never reads and
    // writes through the loader in the same cycle, so no bypass is needed.
    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            rdata_b_q <= '0;
        end else if (re_b_i) begin
            rdata_b_q <= mem_q[raddr_b_i];
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = rdata_b_q;

endmodule : ram16x8

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Owns a 16x8 memory shared between a CPU and a loader.
//   LOAD : CPU held in clear, loader has the memory to itself.
//   START: one-cycle clear pulse for the CPU, loader requests wait.
//   RUN  : CPU runs with priority; loader is served only in cycles with no
//          CPU access, and is aborted with ld_err after TIMEOUT waiting
//          cycles.
//
// Ports
//   clk           in   clock, rising edge
//   clr           in   synchronous reset, active-low
//   cpu_read      in   CPU read strobe
//   cpu_write     in   CPU write strobe (honoured in RUN only)
//   cpu_address   in   CPU address
//   cpu_data_in   in   CPU write data
//   cpu_data_out  out  mem[cpu_address], combinational
//   cpu_clr       out  1 = hold CPU in clear (LOAD, START)
//   go            in   pulse: LOAD -> START
//   stop          in   pulse: START/RUN -> LOAD (wins over go)
//   ld_req        in   loader request, held until ld_ack
//   ld_we         in   loader access type, 1 = write
//   ld_addr       in   loader address
//   ld_wdata      in   loader write data
//   ld_ack        out  one-cycle completion pulse
//   ld_rdata      out  loader read data, held until next read ack
//   ld_err        out  with ld_ack: 1 = aborted by timeout
//   state         out  FSM state (LOAD=00, START=01, RUN=10)
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data_in,
    output logic [DATA_W-1:0] cpu_data_out,
    output logic              cpu_clr,
    input  logic              go,
    input  logic              stop,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_err,
    output logic [1:0]        state
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic              ld_ack_q, ld_ack_d;
    logic              ld_err_q, ld_err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              grant_ok;
    logic              pending;
    logic              grant;
    logic              abort;
    logic              cpu_wr_en;
    logic              ld_wr_en;
    logic              ld_rd_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:  if (go && !stop) state_d = ST_START;
            ST_START: state_d = stop ? ST_LOAD : ST_RUN;
            ST_RUN:   if (stop) state_d = ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Loader arbitration and timeout
    // ------------------------------------------------------------------
    always_comb begin
        grant_ok = 1'b0;
        unique case (state_q)
            ST_LOAD:  grant_ok = 1'b1;
            ST_START: grant_ok = 1'b0;
            ST_RUN:   grant_ok = !cpu_read && !cpu_write;
            default:  grant_ok = 1'b0;
        endcase
    end

    // The ack cycle itself is never a grant cycle, which keeps acks apart.
    assign pending = ld_req && !ld_ack_q;
    assign grant   = pending && grant_ok;
    assign abort   = pending && !grant_ok && (wait_q == TIMEOUT_CNT);

    always_comb begin
        ld_ack_d = grant || abort;
        ld_err_d = abort;
        wait_d   = wait_q;
        if (!ld_req || ld_ack_q || grant || abort) begin
            wait_d = '0;
        end else if (state_q == ST_START || state_q == ST_RUN) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        // In LOAD a pending request is always granted, so a count carried
        // over from a stop mid-wait is simply held until that grant.
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            ld_ack_q <= 1'b0;
            ld_err_q <= 1'b0;
            wait_q   <= '0;
        end else begin
            ld_ack_q <= ld_ack_d;
            ld_err_q <= ld_err_d;
            wait_q   <= wait_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory port muxing
    // ------------------------------------------------------------------
    // A loader grant in RUN requires cpu_write=0, so the two writers never
    // collide; the CPU still takes the mux first for clarity.
    assign cpu_wr_en = (state_q == ST_RUN) && cpu_write;
    assign ld_wr_en  = grant && ld_we;
    assign ld_rd_en  = grant && !ld_we;

    assign mem_we    = cpu_wr_en || ld_wr_en;
    assign mem_waddr = cpu_wr_en ? cpu_address : ld_addr;
    assign mem_wdata = cpu_wr_en ? cpu_data_in : ld_wdata;

    ram16x8 u_ram (
        .clk       (clk),
        .clr_n_i   (clr),
        .raddr_a_i (cpu_address),
        .rdata_a_o (cpu_data_out),
        .re_b_i    (ld_rd_en),
        .raddr_b_i (ld_addr),
        .rdata_b_o (ld_rdata),
        .we_i      (mem_we),
        .waddr_i   (mem_waddr),
        .wdata_i   (mem_wdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cpu_clr = (state_q != ST_RUN);
    assign ld_ack  = ld_ack_q;
    assign ld_err  = ld_err_q;
    assign state   = state_q;

endmodule : mem_ctrl

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
//   Directed self-checking bench for mem_ctrl. Inputs change 1 time unit
//   after a rising edge and outputs are sampled at that same point, well
//   away from the next edge.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       cpu_read, cpu_write;
    logic [3:0] cpu_address;
    logic [7:0] cpu_data_in;
    logic [7:0] cpu_data_out;
    logic       cpu_clr;
    logic       go, stop;
    logic       ld_req, ld_we;
    logic [3:0] ld_addr;
    logic [7:0] ld_wdata;
    logic       ld_ack;
    logic [7:0] ld_rdata;
    logic       ld_err;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .clr          (clr),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_address  (cpu_address),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_clr      (cpu_clr),
        .go           (go),
        .stop         (stop),
        .ld_req       (ld_req),
        .ld_we        (ld_we),
        .ld_addr      (ld_addr),
        .ld_wdata     (ld_wdata),
        .ld_ack       (ld_ack),
        .ld_rdata     (ld_rdata),
        .ld_err       (ld_err),
        .state        (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        cpu_address = a;
        #1;
        d = cpu_data_out;
    endtask

    task automatic ld_start(input logic we, input logic [3:0] a, input logic [7:0] d);
        ld_req   = 1'b1;
        ld_we    = we;
        ld_addr  = a;
        ld_wdata = d;
    endtask

    task automatic go_to_run();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
    endtask

    logic [7:0] rd;
    int         acks;
    int         nonzero;

    initial begin
        clr = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = 4'd0;
        cpu_data_in = 8'd0; go = 1'b0; stop = 1'b0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 4'd0; ld_wdata = 8'd0;
        tick();
        tick();
        clr = 1'b1;

        // ---------------- reset state ----------------
        check("rst_state",   state,    2'b00);
        check("rst_cpu_clr", cpu_clr,  1'b1);
        check("rst_ack",     ld_ack,   1'b0);
        check("rst_err",     ld_err,   1'b0);
        check("rst_rdata",   ld_rdata, 8'h00);

        // ---------------- loader write / read in LOAD ----------------
        ld_start(1'b1, 4'd3, 8'hA5);
        tick();
        check("ldw_ack", ld_ack, 1'b1);
        check("ldw_err", ld_err, 1'b0);
        ld_req = 1'b0;
        tick();
        check("ldw_ack_pulse", ld_ack, 1'b0);
        ld_start(1'b0, 4'd3, 8'h00);
        tick();
        check("ldr_ack",   ld_ack,   1'b1);
        check("ldr_rdata", ld_rdata, 8'hA5);
        ld_req = 1'b0;
        tick();
        check("ldr_hold", ld_rdata, 8'hA5);
        peek(4'd3, rd);
        check("cpu_rd_load", rd, 8'hA5);

        // Request kept high straight after an ack: one dead cycle first.
        ld_start(1'b1, 4'd4, 8'h11);
        tick();
        check("b2b_ack1", ld_ack, 1'b1);
        ld_start(1'b0, 4'd4, 8'h00);
        tick();
        check("b2b_gap", ld_ack, 1'b0);
        tick();
        check("b2b_ack2",  ld_ack,   1'b1);
        check("b2b_rdata", ld_rdata, 8'h11);
        ld_req = 1'b0;
        tick();

        // CPU write in LOAD is ignored.
        cpu_write = 1'b1; cpu_address = 4'd5; cpu_data_in = 8'h77;
        tick();
        cpu_write = 1'b0;
        peek(4'd5, rd);
        check("cpu_wr_load_ign", rd, 8'h00);

        // ---------------- go -> START -> RUN ----------------
        go = 1'b1;
        tick();
        go = 1'b0;
        check("start_state",   state,   2'b01);
        check("start_cpu_clr", cpu_clr, 1'b1);
        cpu_write = 1'b1; cpu_address = 4'd9; cpu_data_in = 8'hFF;
        tick();
        cpu_write = 1'b0;
        check("run_state",   state,   2'b10);
        check("run_cpu_clr", cpu_clr, 1'b0);
        peek(4'd9, rd);
        check("cpu_wr_start_ign", rd, 8'h00);
        cpu_write = 1'b1; cpu_address = 4'd7; cpu_data_in = 8'h3C;
        tick();
        cpu_write = 1'b0;
        peek(4'd7, rd);
        check("cpu_wr_run", rd, 8'h3C);

        // go in RUN is ignored.
        go = 1'b1;
        tick();
        go = 1'b0;
        check("go_ign_run", state, 2'b10);

        // ---------------- RUN: CPU busy 5 cycles, then grant ----------------
        cpu_read = 1'b1; cpu_address = 4'd7;
        ld_start(1'b1, 4'd8, 8'h5A);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ld_ack) acks++;
        end
        check("busy_no_ack", acks, 0);
        check("busy_cpu_data", cpu_data_out, 8'h3C);
        cpu_read = 1'b0;
        tick();
        check("idle_grant_ack", ld_ack, 1'b1);
        check("idle_grant_err", ld_err, 1'b0);
        ld_req = 1'b0;
        peek(4'd8, rd);
        check("idle_grant_mem", rd, 8'h5A);
        peek(4'd7, rd);
        check("cpu_data_intact", rd, 8'h3C);
        tick();

        // ---------------- RUN: timeout ----------------
        cpu_read = 1'b1; cpu_address = 4'd0;
        ld_start(1'b1, 4'd7, 8'hEE);
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ld_ack) acks++;
        end
        check("to_wait_no_ack", acks, 0);
        tick();
        check("to_ack",   ld_ack,   1'b1);
        check("to_err",   ld_err,   1'b1);
        check("to_rdata", ld_rdata, 8'h11);
        ld_req = 1'b0;
        cpu_read = 1'b0;
        peek(4'd7, rd);
        check("to_mem_unchanged", rd, 8'h3C);
        tick();
        check("to_ack_pulse", ld_ack, 1'b0);

        // ---------------- stop mid-wait: granted in LOAD ----------------
        cpu_read = 1'b1;
        ld_start(1'b1, 4'd10, 8'h42);
        tick();
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        cpu_read = 1'b0;
        check("stop_state", state,  2'b00);
        check("stop_noack", ld_ack, 1'b0);
        tick();
        check("stop_grant_ack", ld_ack, 1'b1);
        check("stop_grant_err", ld_err, 1'b0);
        ld_req = 1'b0;
        peek(4'd10, rd);
        check("stop_grant_mem", rd, 8'h42);
        tick();

        // ---------------- go+stop together ----------------
        go = 1'b1; stop = 1'b1;
        tick();
        go = 1'b0; stop = 1'b0;
        check("gostop_load", state, 2'b00);
        go_to_run();
        check("gostop_run_pre", state, 2'b10);
        go = 1'b1; stop = 1'b1;
        tick();
        go = 1'b0; stop = 1'b0;
        check("gostop_run_state",   state,   2'b00);
        check("gostop_run_cpu_clr", cpu_clr, 1'b1);

        // stop from START.
        go = 1'b1;
        tick();
        go = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("start_stop", state, 2'b00);

        // ---------------- reset mid-wait ----------------
        go_to_run();
        cpu_read = 1'b1;
        ld_start(1'b0, 4'd3, 8'h00);
        for (int i = 0; i < 4; i++) tick();
        clr = 1'b0;
        tick();
        clr = 1'b1;
        ld_req = 1'b0;
        cpu_read = 1'b0;
        check("mrst_state", state,    2'b00);
        check("mrst_ack",   ld_ack,   1'b0);
        check("mrst_rdata", ld_rdata, 8'h00);
        nonzero = 0;
        for (int a = 0; a < 16; a++) begin
            logic [3:0] a4;
            a4 = 4'(a);
            @(negedge clk);
            peek(a4, rd);
            if (rd != 8'h00) nonzero++;
        end
        check("mrst_mem_zero", nonzero, 0);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ld_ack) acks++;
        end
        check("mrst_no_stray_ack", acks, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_ctrl
